period_finder_scheduler: RTL
============================

// Module: period_finder_scheduler
// PURPOSE
//   Shares one classical_period_finder among NUM_REQ requesters. Jobs are
//   granted round-robin, one at a time. The block drives the finder's
//   start/done handshake and aborts runaway jobs with a watchdog. It returns
//   {period, mu_counter, status} to the requester that issued the job.
//   It sits between the host job ports and a single finder instance.
// PARAMETERS
//   WIDTH          8    operand/result width; must match the finder's WIDTH
//   NUM_REQ        4    number of requester ports (>=2)
//   TIMEOUT_CYCLES 512  max cycles in ISSUE before abort (>=2)
// PORTS
//   clk          in   1              single clock, rising edge
//   reset        in   1              synchronous, active-high
//   req_valid    in   NUM_REQ        per-requester job valid
//   req_ready    out  NUM_REQ        one-hot grant; transfer on valid&ready
//   req_modulus  in   NUM_REQ*WIDTH  flat, requester i at [i*WIDTH +: WIDTH]
//   req_base     in   NUM_REQ*WIDTH  flat, same packing
//   rsp_valid    out  1              response valid; held until rsp_ready
//   rsp_ready    in   1              response accept
//   rsp_id       out  clog2(NUM_REQ) index of the originating requester
//   rsp_period   out  WIDTH          period result
//   rsp_mu       out  WIDTH          finder mu_counter result
//   rsp_status   out  2              00 ok, 01 timeout, 10 bad modulus (==0)
//   pf_reset_n   out  1              finder reset (active-low)
//   pf_start     out  1              finder start
//   pf_modulus   out  WIDTH          finder modulus, stable while pf_start=1
//   pf_base      out  WIDTH          finder base, stable while pf_start=1
//   pf_done      in   1              finder done
//   pf_period    in   WIDTH          finder period
//   pf_mu        in   WIDTH          finder mu_counter
// BEHAVIOUR
// - Reset (reset=1 at clk edge):
//   - State IDLE; rr pointer = 0; req_ready = 0.
//   - rsp_valid = 0; all rsp_* and pf_modulus/pf_base = 0; pf_start = 0.
//   - pf_reset_n = 0 for every cycle reset is high, so the finder is held reset.
//   - A reset mid-job drops the job silently; no response is produced.
// - IDLE: req_ready is combinational, only in IDLE, only when rsp_valid=0.
//   - Winner = first i with req_valid[i], searching from ptr, ptr+1, ... mod NUM_REQ.
//   - On transfer: latch operands and id; ptr <= winner+1 (wraps).
//   - modulus==0: go to RESP with status 10, period=0, mu=0; the finder is not touched.
//   - Otherwise: go to ISSUE.
// - ISSUE: pf_start=1 with latched operands; the watchdog counts from 0, +1 per cycle.
//   - pf_done=1: capture pf_period/pf_mu, status 00, go to DRAIN.
//   - Watchdog reaches TIMEOUT_CYCLES-1 with pf_done=0: go to ABORT.
//   - If pf_done and the watchdog expire in the same cycle, pf_done wins.
// - DRAIN: pf_start=0. Stay until pf_done=0 (the finder has returned to IDLE),
//   then go to RESP. pf_start is never reasserted while pf_done=1.
// - ABORT: pf_start=0, pf_reset_n=0 for exactly 2 cycles.
//   - Then RESP with status 01, period=0, mu=0.
// - RESP: rsp_valid=1, outputs stable. On rsp_ready: rsp_valid <= 0, go to IDLE.
//   - The next grant is possible in the cycle after acceptance.
// - Only one job is outstanding; no other requester is granted until the response is accepted.
// - Latency: transfer -> pf_start next cycle. Finder done -> rsp_valid after DRAIN,
//   typically 2-3 cycles.
// - Fairness: a requester holding req_valid waits at most NUM_REQ-1 jobs.
// - pf_reset_n=1 in all states other than reset and ABORT.
// - req_valid may drop without a grant; no job is recorded.
// TESTING
// - req0 base=2 mod=7 -> pf_start=1 the next cycle; rsp id=0, period=3, mu=2, status=00.
// - req0 base=3 mod=7 -> rsp period=6, mu=5, status=00; no second pf_start until pf_done=0.
// - req1 base=2 mod=6 -> no pf_done; ABORT pf_reset_n=0 for 2 cycles; rsp status=01,
//   period=0; a following job base=2 mod=7 still returns 3.
// - req2 mod=0 -> rsp status=10 one cycle after transfer; pf_start never asserted.
// - All 4 req_valid high, rsp_ready=1 -> grant order 0,1,2,3,0; rsp_id matches each grant.
// - Reset pulse during ISSUE -> rsp_valid=0, pf_reset_n=0 during reset; a new job after
//   reset returns correct results.

Source files
------------

// File: rtl/period_finder_scheduler.sv
// Round-robin scheduler that time-shares one classical_period_finder among
// NUM_REQ requesters, with a start/done handshake, a watchdog abort and a response port.
module period_finder_scheduler #(
  parameter int WIDTH          = 8,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 512
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_modulus,
  input  logic [NUM_REQ*WIDTH-1:0]   req_base,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [WIDTH-1:0]           rsp_period,
  output logic [WIDTH-1:0]           rsp_mu,
  output logic [1:0]                 rsp_status,
  output logic                       pf_reset_n,
  output logic                       pf_start,
  output logic [WIDTH-1:0]           pf_modulus,
  output logic [WIDTH-1:0]           pf_base,
  input  logic                       pf_done,
  input  logic [WIDTH-1:0]           pf_period,
  input  logic [WIDTH-1:0]           pf_mu
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int WDW = $clog2(TIMEOUT_CYCLES);

  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_REQ - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_ABORT = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_BADMOD  = 2'b10;

  logic [2:0]       state_q,  state_d;
  logic [IDW-1:0]   ptr_q,    ptr_d;
  logic [IDW-1:0]   id_q,     id_d;
  logic [WIDTH-1:0] mod_q,    mod_d;
  logic [WIDTH-1:0] base_q,   base_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] mu_q,     mu_d;
  logic [1:0]       status_q, status_d;
  logic [WDW-1:0]   wdog_q,   wdog_d;
  logic             abort_q,  abort_d;

  logic             found;
  logic [IDW-1:0]   winner;
  logic [IDW-1:0]   cand_idx;
  int unsigned      cand;
  logic [WIDTH-1:0] win_mod;
  logic [WIDTH-1:0] win_base;
  logic             grant;

  // Round-robin search starting at ptr_q; the first valid requester wins.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand     = (32'(ptr_q) + i) % NUM_REQ;
      cand_idx = IDW'(cand);
      if (!found && req_valid[cand_idx]) begin
        found  = 1'b1;
        winner = cand_idx;
      end
    end
  end

  always_comb begin
    win_mod  = '0;
    win_base = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (winner == IDW'(i)) begin
        win_mod  = req_modulus[i*WIDTH +: WIDTH];
        win_base = req_base[i*WIDTH +: WIDTH];
      end
    end
  end

  assign rsp_valid = (state_q == S_RESP);
  assign grant     = (state_q == S_IDLE) && !rsp_valid && found && !reset;

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[winner] = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    mod_d    = mod_q;
    base_d   = base_q;
    period_d = period_q;
    mu_d     = mu_q;
    status_d = status_q;
    wdog_d   = wdog_q;
    abort_d  = abort_q;
    case (state_q)
      S_IDLE: begin
        if (grant) begin
          id_d   = winner;
          mod_d  = win_mod;
          base_d = win_base;
          ptr_d  = (winner == LAST_ID) ? '0 : winner + 1'b1;
          wdog_d = '0;
          // A zero modulus never reaches the finder; answer directly.
          if (win_mod == '0) begin
            state_d  = S_RESP;
            status_d = ST_BADMOD;
            period_d = '0;
            mu_d     = '0;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (pf_done) begin
          period_d = pf_period;
          mu_d     = pf_mu;
          status_d = ST_OK;
          state_d  = S_DRAIN;
        end else if (wdog_q == WD_LAST) begin
          abort_d = 1'b0;
          state_d = S_ABORT;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (!pf_done) state_d = S_RESP;
      end
      S_ABORT: begin
        if (abort_q) begin
          status_d = ST_TIMEOUT;
          period_d = '0;
          mu_d     = '0;
          state_d  = S_RESP;
        end else begin
          abort_d = 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      id_q     <= '0;
      mod_q    <= '0;
      base_q   <= '0;
      period_q <= '0;
      mu_q     <= '0;
      status_q <= '0;
      wdog_q   <= '0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      mod_q    <= mod_d;
      base_q   <= base_d;
      period_q <= period_d;
      mu_q     <= mu_d;
      status_q <= status_d;
      wdog_q   <= wdog_d;
      abort_q  <= abort_d;
    end
  end

  assign rsp_id     = id_q;
  assign rsp_period = period_q;
  assign rsp_mu     = mu_q;
  assign rsp_status = status_q;
  assign pf_start   = (state_q == S_ISSUE);
  assign pf_modulus = mod_q;
  assign pf_base    = base_q;
  assign pf_reset_n = !reset && (state_q != S_ABORT);

endmodule
